// File: rtl/gf16_mul_pipe.sv
// Multi-lane pipelined GF(2^4) arithmetic unit (x^4+x+1) with MUL/SQR/INV/ADD per beat,
// elastic valid/ready stages, per-lane output parity and a saturating zero-inversion counter.
module gf16_mul_pipe #(
    parameter int LANES = 4,
    parameter int PIPE  = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [4*LANES-1:0] in_a,
    input  logic [4*LANES-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*LANES-1:0] out_d,
    output logic [LANES-1:0]   out_par,
    output logic [1:0]         out_op,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   zinv_cnt
);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_SQR = 2'b01;
    localparam logic [1:0] OP_INV = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
        $error("gf16_mul_pipe: PIPE must be in 1..4");
    end
    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
        $error("gf16_mul_pipe: LANES must be in 1..16");
    end

    // Shift-and-add product followed by reduction of x^6..x^4 with x^4 = x + 1.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) p = p ^ (7'(a) << k);
        end
        for (int k = 6; k >= 4; k--) begin
            if (p[k]) p = p ^ (7'(5'b10011) << (k - 4));
        end
        return p[3:0];
    endfunction

    // Squaring is linear in GF(2^m): spread the bits, then fold x^4 and x^6.
    function automatic logic [3:0] gf_sqr(input logic [3:0] a);
        return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
    endfunction

    // A^14 = A^8 * A^4 * A^2; zero maps to zero without a special case.
    function automatic logic [3:0] gf_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf_sqr(a);
        a4 = gf_sqr(a2);
        a8 = gf_sqr(a4);
        return gf_mul(gf_mul(a8, a4), a2);
    endfunction

    function automatic logic [3:0] lane_op(input logic [1:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
        logic [3:0] r;
        case (op)
            OP_MUL:  r = gf_mul(a, b);
            OP_SQR:  r = gf_sqr(a);
            OP_INV:  r = gf_inv(a);
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [4:0] inc);
        logic [CNT_W+5:0] s;
        logic [CNT_W+5:0] top;
        s   = (CNT_W+6)'(c) + (CNT_W+6)'(inc);
        top = (CNT_W+6)'({CNT_W{1'b1}});
        return (s > top) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [4*LANES-1:0] res;
    logic [4:0]         zero_lanes;

    always_comb begin
        res        = '0;
        zero_lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            res[4*i +: 4] = lane_op(in_op, in_a[4*i +: 4], in_b[4*i +: 4]);
            if (in_op == OP_INV && in_a[4*i +: 4] == 4'h0) zero_lanes = zero_lanes + 5'd1;
        end
    end

    logic [PIPE-1:0]    vld;
    logic [PIPE-1:0]    load;
    logic [PIPE-1:0]    move;
    logic [4*LANES-1:0] d_q  [PIPE];
    logic [1:0]         op_q [PIPE];

    // Stall chain runs from the output back to the input so bubbles collapse.
    always_comb begin
        load         = '0;
        move         = '0;
        move[PIPE-1] = vld[PIPE-1] & out_ready;
        load[PIPE-1] = ~vld[PIPE-1] | move[PIPE-1];
        for (int k = PIPE - 2; k >= 0; k--) begin
            move[k] = vld[k] & load[k+1];
            load[k] = ~vld[k] | move[k];
        end
    end

    assign in_ready = load[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < PIPE; k++) begin
                d_q[k]  <= '0;
                op_q[k] <= '0;
            end
        end else begin
            // stage 0: capture the combinational result of the accepted beat
            if (load[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    d_q[0]  <= res;
                    op_q[0] <= in_op;
                end
            end
            // stages 1..PIPE-1: carry result, op and valid
            for (int k = 1; k < PIPE; k++) begin
                if (load[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        d_q[k]  <= d_q[k-1];
                        op_q[k] <= op_q[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = vld[PIPE-1];
    assign out_d     = d_q[PIPE-1];
    assign out_op    = op_q[PIPE-1];

    always_comb begin
        out_par = '0;
        for (int i = 0; i < LANES; i++) out_par[i] = ^out_d[4*i +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zinv_cnt <= '0;
        end else if (cnt_clr) begin
            zinv_cnt <= '0;
        end else if (in_valid && in_ready && zero_lanes != 5'd0) begin
            zinv_cnt <= sat_add(zinv_cnt, zero_lanes);
        end
    end

endmodule

// File: tb/tb_gf16_mul_pipe.sv
// Directed and streamed checks of gf16_mul_pipe against a log/antilog GF(2^4) model;
// a second and third instance cover PIPE=4 with a 4-bit counter and PIPE=1 with one lane.
module tb_gf16_mul_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic [15:0] out_d;
    logic [3:0]  out_par;
    logic [1:0]  out_op;
    logic        cnt_clr;
    logic [7:0]  zinv_cnt;

    logic        p4_in_valid, p4_in_ready, p4_out_valid, p4_out_ready, p4_cnt_clr;
    logic [1:0]  p4_in_op, p4_out_op;
    logic [15:0] p4_in_a, p4_in_b, p4_out_d;
    logic [3:0]  p4_out_par, p4_zinv_cnt;

    logic        p1_in_valid, p1_in_ready, p1_out_valid, p1_out_ready, p1_cnt_clr;
    logic [1:0]  p1_in_op, p1_out_op;
    logic [3:0]  p1_in_a, p1_in_b, p1_out_d;
    logic [0:0]  p1_out_par;
    logic [7:0]  p1_zinv_cnt;

    gf16_mul_pipe #(.LANES(4), .PIPE(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d),
        .out_par(out_par), .out_op(out_op), .cnt_clr(cnt_clr), .zinv_cnt(zinv_cnt));

    gf16_mul_pipe #(.LANES(4), .PIPE(4), .CNT_W(4)) dut_p4 (
        .clk(clk), .rst_n(rst_n), .in_valid(p4_in_valid), .in_ready(p4_in_ready), .in_op(p4_in_op),
        .in_a(p4_in_a), .in_b(p4_in_b), .out_valid(p4_out_valid), .out_ready(p4_out_ready),
        .out_d(p4_out_d), .out_par(p4_out_par), .out_op(p4_out_op), .cnt_clr(p4_cnt_clr),
        .zinv_cnt(p4_zinv_cnt));

    gf16_mul_pipe #(.LANES(1), .PIPE(1), .CNT_W(8)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .in_valid(p1_in_valid), .in_ready(p1_in_ready), .in_op(p1_in_op),
        .in_a(p1_in_a), .in_b(p1_in_b), .out_valid(p1_out_valid), .out_ready(p1_out_ready),
        .out_d(p1_out_d), .out_par(p1_out_par), .out_op(p1_out_op), .cnt_clr(p1_cnt_clr),
        .zinv_cnt(p1_zinv_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_in = 0;
    int n_out = 0;
    int exp_cnt = 0;
    bit rnd_rdy = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  op;
    } exp_t;
    exp_t exp_q[$];

    logic        hold_vld = 1'b0;
    logic [15:0] hold_d;
    logic [1:0]  hold_op;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] gexp(input int i);
        case (i)
            0: return 4'h1;  1: return 4'h2;  2: return 4'h4;  3: return 4'h8;
            4: return 4'h3;  5: return 4'h6;  6: return 4'hC;  7: return 4'hB;
            8: return 4'h5;  9: return 4'hA; 10: return 4'h7; 11: return 4'hE;
            12: return 4'hF; 13: return 4'hD; default: return 4'h9;
        endcase
    endfunction

    function automatic int glog(input logic [3:0] a);
        for (int i = 0; i < 15; i++) if (gexp(i) == a) return i;
        return 0;
    endfunction

    function automatic logic [3:0] m_lane(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00: return (a == 0 || b == 0) ? 4'h0 : gexp((glog(a) + glog(b)) % 15);
            2'b01: return (a == 0) ? 4'h0 : gexp((2 * glog(a)) % 15);
            2'b10: return (a == 0) ? 4'h0 : gexp((15 - glog(a)) % 15);
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [15:0] m_beat(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        for (int l = 0; l < 4; l++) r[4*l +: 4] = m_lane(op, a[4*l +: 4], b[4*l +: 4]);
        return r;
    endfunction

    function automatic int m_zeros(input logic [1:0] op, input logic [15:0] a);
        int z = 0;
        for (int l = 0; l < 4; l++) if (op == 2'b10 && a[4*l +: 4] == 4'h0) z++;
        return z;
    endfunction

    function automatic logic [3:0] par_of(input logic [15:0] d);
        logic [3:0] p;
        for (int l = 0; l < 4; l++) p[l] = ^d[4*l +: 4];
        return p;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) if (rnd_rdy) begin
        #1 out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt  = 0;
            hold_vld = 1'b0;
        end else begin
            check("zinv", zinv_cnt, exp_cnt);
            if (hold_vld && out_valid) begin
                check("hold_d", out_d, hold_d);
                check("hold_op", out_op, hold_op);
            end
            hold_vld = out_valid && !out_ready;
            hold_d   = out_d;
            hold_op  = out_op;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_d", out_d, e.d);
                    check("sb_par", out_par, par_of(e.d));
                    check("sb_op", out_op, e.op);
                end
                n_out++;
            end
            if (cnt_clr) exp_cnt = 0;
            if (in_valid && in_ready) begin
                e.d  = m_beat(in_op, in_a, in_b);
                e.op = in_op;
                exp_q.push_back(e);
                n_in++;
                if (!cnt_clr) exp_cnt = (exp_cnt + m_zeros(in_op, in_a) > 255) ? 255 : exp_cnt + m_zeros(in_op, in_a);
            end
        end
    end

    task automatic directed(input string tag, input logic [1:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] exp_d);
        @(posedge clk); #1;
        check({tag, "_rdy"}, in_ready, 1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_early"}, out_valid, 0);
        @(posedge clk); #1;
        check({tag, "_vld"}, out_valid, 1);
        check({tag, "_d"}, out_d, exp_d);
        check({tag, "_par"}, out_par, par_of(exp_d));
        check({tag, "_op"}, out_op, op);
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        bit done = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    initial begin
        int t0, acc, idx;
        logic [15:0] a, b;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        p4_in_valid = 1'b0; p4_in_op = '0; p4_in_a = '0; p4_in_b = '0; p4_out_ready = 1'b1; p4_cnt_clr = 1'b0;
        p1_in_valid = 1'b0; p1_in_op = '0; p1_in_a = '0; p1_in_b = '0; p1_out_ready = 1'b1; p1_cnt_clr = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_d", out_d, 0);
        check("rst_out_par", out_par, 0);
        check("rst_out_op", out_op, 0);
        check("rst_zinv", zinv_cnt, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        directed("mul28", 2'b00, 16'h2222, 16'h8888, 16'h3333);
        directed("mulff", 2'b00, 16'hFFFF, 16'hFFFF, 16'hAAAA);
        directed("sqr3", 2'b01, 16'h3333, 16'h0000, 16'h5555);
        directed("inv2", 2'b10, 16'h2222, 16'h0000, 16'h9999);
        directed("inv0", 2'b10, 16'h1110, 16'h0000, 16'h1110);
        check("zinv_one", zinv_cnt, 1);
        directed("add", 2'b11, 16'h6666, 16'hCCCC, 16'hAAAA);

        t0 = cyc;
        for (int op = 0; op < 4; op++) begin
            for (int p = 0; p < 64; p++) begin
                for (int l = 0; l < 4; l++) begin
                    idx = p * 4 + l;
                    a[4*l +: 4] = 4'(idx >> 4);
                    b[4*l +: 4] = 4'(idx);
                end
                send(2'(op), a, b);
            end
        end
        check("throughput", cyc - t0, 256);
        repeat (5) @(posedge clk); #1;
        check("exh_count", n_out, n_in);
        check("exh_empty", exp_q.size(), 0);

        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_op = 2'b11; in_a = 16'(acc * 16'h1111); in_b = 16'h0F0F;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        check("bp_absorbed", acc, 2);
        check("bp_in_ready", in_ready, 0);
        rnd_rdy = 1;
        for (int i = 2; i < 32; i++) send(2'(i), 16'(i * 16'h0137), 16'(i * 16'h1021));
        rnd_rdy = 0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (8) @(posedge clk); #1;
        check("bp_count", n_out, n_in);
        check("bp_empty", exp_q.size(), 0);

        out_ready = 1'b0;
        send(2'b10, 16'h0000, 16'h0000);
        send(2'b11, 16'h1234, 16'h4321);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_zinv", zinv_cnt, 0);
        check("mrst_out_d", out_d, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("mrst_no_out", out_valid, 0);
        directed("post_rst", 2'b00, 16'h2222, 16'h8888, 16'h3333);

        @(posedge clk); #1;
        p4_in_valid = 1'b1; p4_in_op = 2'b00; p4_in_a = 16'hFFFF; p4_in_b = 16'hFFFF;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            p4_in_valid = 1'b0;
            check($sformatf("p4_vld_e%0d", e), p4_out_valid, (e == 4) ? 1 : 0);
        end
        check("p4_d", p4_out_d, 16'hAAAA);
        for (int i = 0; i < 5; i++) begin
            p4_in_valid = 1'b1; p4_in_op = 2'b10; p4_in_a = 16'h0000;
            @(posedge clk); #1;
            p4_in_valid = 1'b0;
            check($sformatf("p4_sat%0d", i), p4_zinv_cnt, (4 * (i + 1) > 15) ? 15 : 4 * (i + 1));
        end
        p4_in_valid = 1'b1; p4_cnt_clr = 1'b1;
        @(posedge clk); #1;
        p4_in_valid = 1'b0; p4_cnt_clr = 1'b0;
        check("p4_clr_wins", p4_zinv_cnt, 0);

        p1_in_valid = 1'b1; p1_in_op = 2'b01; p1_in_a = 4'h3;
        @(posedge clk); #1;
        p1_in_valid = 1'b0;
        check("p1_vld", p1_out_valid, 1);
        check("p1_d", p1_out_d, 4'h5);
        check("p1_par", p1_out_par, 0);
        @(posedge clk); #1;
        check("p1_empty", p1_out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
